biriscv_fetch_queue: RTL and testbench

- Dual-slot in-order instruction queue between the frontend decode outputs (fetch0/fetch1) and the issue stage.
- Decouples decode from issue stalls: absorbs up to DEPTH decoded instructions and presents the oldest two to issue.
- Flushed on branch redirect.
- Each entry holds instr, pc, fault bits and 9 decode flags (exec, lsu, branch, mul, div, csr, rd_valid, invalid, mule).

---
 rtl/biriscv_fetchq_pkg.sv | 30 +++
 rtl/biriscv_fetchq_ram.sv | 38 +++
 rtl/biriscv_fetch_queue.sv | 121 ++++++++++++
 tb/tb_biriscv_fetch_queue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/biriscv_fetchq_pkg.sv
// Shared definitions for the biriscv fetch queue: entry layout, flag indices
// and a packing helper.
package biriscv_fetchq_pkg;

  localparam int ENTRY_W   = 75;
  localparam int INSTR_LSB = 0;
  localparam int PC_LSB    = 32;
  localparam int FAULT_LSB = 64;
  localparam int FLAGS_LSB = 66;

  localparam int FLAG_EXEC     = 0;
  localparam int FLAG_LSU      = 1;
  localparam int FLAG_BRANCH   = 2;
  localparam int FLAG_MUL      = 3;
  localparam int FLAG_DIV      = 4;
  localparam int FLAG_CSR      = 5;
  localparam int FLAG_RD_VALID = 6;
  localparam int FLAG_INVALID  = 7;
  localparam int FLAG_MULE     = 8;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t pack_entry(input logic [31:0] instr,
                                        input logic [31:0] pc,
                                        input logic [1:0]  fault,
                                        input logic [8:0]  flags);
    return {flags, fault, pc, instr};
  endfunction

endpackage

// File: rtl/biriscv_fetchq_ram.sv
// DEPTH x WIDTH register file, two write ports, two async read ports.
// Write port 1 wins on an address collision.
module biriscv_fetchq_ram
  import biriscv_fetchq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int WIDTH   = ENTRY_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we0_i,
  input  logic [DEPTH_W-1:0] wa0_i,
  input  logic [WIDTH-1:0]   wd0_i,
  input  logic               we1_i,
  input  logic [DEPTH_W-1:0] wa1_i,
  input  logic [WIDTH-1:0]   wd1_i,
  input  logic [DEPTH_W-1:0] ra0_i,
  input  logic [DEPTH_W-1:0] ra1_i,
  output logic [WIDTH-1:0]   rd0_o,
  output logic [WIDTH-1:0]   rd1_o
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_mem <= '0;
    end else begin
      if (we0_i) r_mem[wa0_i] <= wd0_i;
      if (we1_i) r_mem[wa1_i] <= wd1_i;
    end
  end

  assign rd0_o = r_mem[ra0_i];
  assign rd1_o = r_mem[ra1_i];

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Dual-slot in-order instruction queue between decode and issue.
// Optional same-cycle bypass when empty: define BIRISCV_FETCHQ_BYPASS_EN.
module biriscv_fetch_queue
  import biriscv_fetchq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in0_valid_i,
  input  logic [31:0]        in0_instr_i,
  input  logic [31:0]        in0_pc_i,
  input  logic [1:0]         in0_fault_i,
  input  logic [8:0]         in0_flags_i,
  output logic               in0_accept_o,
  input  logic               in1_valid_i,
  input  logic [31:0]        in1_instr_i,
  input  logic [31:0]        in1_pc_i,
  input  logic [1:0]         in1_fault_i,
  input  logic [8:0]         in1_flags_i,
  output logic               in1_accept_o,
  output logic               out0_valid_o,
  output logic [31:0]        out0_instr_o,
  output logic [31:0]        out0_pc_o,
  output logic [1:0]         out0_fault_o,
  output logic [8:0]         out0_flags_o,
  input  logic               out0_accept_i,
  output logic               out1_valid_o,
  output logic [31:0]        out1_instr_o,
  output logic [31:0]        out1_pc_o,
  output logic [1:0]         out1_fault_o,
  output logic [8:0]         out1_flags_o,
  input  logic               out1_accept_i,
  output logic [DEPTH_W:0]   level_o
);

  localparam logic [DEPTH_W:0] L_DEPTH = (DEPTH_W+1)'(DEPTH);

  logic [DEPTH_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [DEPTH_W:0]   r_count;

  logic [DEPTH_W:0] w_free;
  logic             w_push0, w_push1, w_pop0, w_pop1;
  logic [1:0]       w_push_cnt, w_pop_cnt;
  entry_t           w_e1, w_slot0, w_rd0, w_rd1, w_out0, w_out1;
  logic             w_slot0_vld, w_slot1_vld, w_byp, w_we0, w_we1;

  // Accepts look only at registered occupancy; same-cycle pops never make room.
  assign w_free       = L_DEPTH - r_count;
  assign in0_accept_o = rst_i & (w_free != '0);
  assign in1_accept_o = rst_i & (in0_valid_i ? (w_free >= (DEPTH_W+1)'(2)) : (w_free != '0));

  assign w_push0    = in0_valid_i & in0_accept_o;
  assign w_push1    = in1_valid_i & in1_accept_o;
  assign w_push_cnt = {1'b0, w_push0} + {1'b0, w_push1};

  // Compact the accepted instructions into slot0/slot1 in program order.
  assign w_e1        = pack_entry(in1_instr_i, in1_pc_i, in1_fault_i, in1_flags_i);
  assign w_slot0     = w_push0 ? pack_entry(in0_instr_i, in0_pc_i, in0_fault_i, in0_flags_i) : w_e1;
  assign w_slot0_vld = w_push0 | w_push1;
  assign w_slot1_vld = w_push0 & w_push1;

`ifdef BIRISCV_FETCHQ_BYPASS_EN
  assign w_byp = (r_count == '0) & ~flush_i;
`else
  assign w_byp = 1'b0;
`endif

  assign out0_valid_o = rst_i & (w_byp ? w_slot0_vld : (r_count != '0));
  assign out1_valid_o = rst_i & (w_byp ? w_slot1_vld : (r_count >= (DEPTH_W+1)'(2)));
  assign w_out0       = !rst_i ? '0 : (w_byp ? w_slot0 : w_rd0);
  assign w_out1       = !rst_i ? '0 : (w_byp ? w_e1    : w_rd1);

  assign out0_instr_o = w_out0[INSTR_LSB +: 32];
  assign out0_pc_o    = w_out0[PC_LSB    +: 32];
  assign out0_fault_o = w_out0[FAULT_LSB +: 2];
  assign out0_flags_o = w_out0[FLAGS_LSB +: 9];
  assign out1_instr_o = w_out1[INSTR_LSB +: 32];
  assign out1_pc_o    = w_out1[PC_LSB    +: 32];
  assign out1_fault_o = w_out1[FAULT_LSB +: 2];
  assign out1_flags_o = w_out1[FLAGS_LSB +: 9];
  assign level_o      = rst_i ? r_count : '0;

  assign w_pop0    = out0_valid_o & out0_accept_i;
  assign w_pop1    = w_pop0 & out1_valid_o & out1_accept_i;
  assign w_pop_cnt = {1'b0, w_pop0} + {1'b0, w_pop1};

  // Bypassed-and-consumed slots keep their pointer advance but skip the write.
  assign w_we0 = rst_i & ~flush_i & w_slot0_vld & ~(w_byp & w_pop0);
  assign w_we1 = rst_i & ~flush_i & w_slot1_vld & ~(w_byp & w_pop1);

  biriscv_fetchq_ram #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .WIDTH(ENTRY_W)) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we0_i (w_we0),
    .wa0_i (r_wr_ptr),
    .wd0_i (w_slot0),
    .we1_i (w_we1),
    .wa1_i (r_wr_ptr + DEPTH_W'(1)),
    .wd1_i (w_e1),
    .ra0_i (r_rd_ptr),
    .ra1_i (r_rd_ptr + DEPTH_W'(1)),
    .rd0_o (w_rd0),
    .rd1_o (w_rd1)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + DEPTH_W'(w_pop_cnt);
      r_wr_ptr <= r_wr_ptr + DEPTH_W'(w_push_cnt);
      r_count  <= r_count + (DEPTH_W+1)'(w_push_cnt) - (DEPTH_W+1)'(w_pop_cnt);
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Randomized + directed bench for biriscv_fetch_queue against a queue-based model.
module tb_biriscv_fetch_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
    logic [8:0]  flags;
  } ent_t;

  logic        clk_i = 1'b0, rst_i = 1'b0, flush_i = 1'b0;
  logic        in0_valid_i = 0, in1_valid_i = 0, out0_accept_i = 0, out1_accept_i = 0;
  logic [31:0] in0_instr_i = 0, in0_pc_i = 0, in1_instr_i = 0, in1_pc_i = 0;
  logic [1:0]  in0_fault_i = 0, in1_fault_i = 0;
  logic [8:0]  in0_flags_i = 0, in1_flags_i = 0;
  logic        in0_accept_o, in1_accept_o, out0_valid_o, out1_valid_o;
  logic [31:0] out0_instr_o, out0_pc_o, out1_instr_o, out1_pc_o;
  logic [1:0]  out0_fault_o, out1_fault_o;
  logic [8:0]  out0_flags_o, out1_flags_o;
  logic [3:0]  level_o;

  biriscv_fetch_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in0_valid_i(in0_valid_i), .in0_instr_i(in0_instr_i), .in0_pc_i(in0_pc_i),
    .in0_fault_i(in0_fault_i), .in0_flags_i(in0_flags_i), .in0_accept_o(in0_accept_o),
    .in1_valid_i(in1_valid_i), .in1_instr_i(in1_instr_i), .in1_pc_i(in1_pc_i),
    .in1_fault_i(in1_fault_i), .in1_flags_i(in1_flags_i), .in1_accept_o(in1_accept_o),
    .out0_valid_o(out0_valid_o), .out0_instr_o(out0_instr_o), .out0_pc_o(out0_pc_o),
    .out0_fault_o(out0_fault_o), .out0_flags_o(out0_flags_o), .out0_accept_i(out0_accept_i),
    .out1_valid_o(out1_valid_o), .out1_instr_o(out1_instr_o), .out1_pc_o(out1_pc_o),
    .out1_fault_o(out1_fault_o), .out1_flags_o(out1_flags_o), .out1_accept_i(out1_accept_i),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0, bad = 0;
  ent_t        q[$];
  logic [31:0] next_pc = 32'h1000;
  logic [31:0] last_pc = 32'h0;
  string       phase = "init";

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational view, then advance the model.
  task automatic step(input bit v0, input bit v1, input bit a0, input bit a1,
                      input bit fl, input bit rs, input logic [31:0] i0, input logic [31:0] i1);
    ent_t e0, e1;
    ent_t lst[$];
    ent_t vis[$];
    int   free;
    bit   ea0, ea1, p0, p1, ev0, ev1, c0, c1;
    @(negedge clk_i);
    e0.instr = i0; e0.pc = next_pc;
    e0.fault = 2'($urandom); e0.flags = 9'($urandom);
    e1.instr = i1; e1.pc = next_pc + (v0 ? 32'd4 : 32'd0);
    e1.fault = 2'($urandom); e1.flags = 9'($urandom);
    rst_i = rs; flush_i = fl;
    in0_valid_i = v0; in0_instr_i = e0.instr; in0_pc_i = e0.pc;
    in0_fault_i = e0.fault; in0_flags_i = e0.flags;
    in1_valid_i = v1; in1_instr_i = e1.instr; in1_pc_i = e1.pc;
    in1_fault_i = e1.fault; in1_flags_i = e1.flags;
    out0_accept_i = a0; out1_accept_i = a1;
    #1;
    free = DEPTH - q.size();
    ea0 = rs && free >= 1;
    ea1 = rs && (v0 ? free >= 2 : free >= 1);
    p0 = v0 && ea0;
    p1 = v1 && ea1;
    lst = q;
    if (p0) lst.push_back(e0);
    if (p1) lst.push_back(e1);
`ifdef BIRISCV_FETCHQ_BYPASS_EN
    vis = (q.size() == 0 && !fl) ? lst : q;
`else
    vis = q;
`endif
    ev0 = rs && vis.size() >= 1;
    ev1 = rs && vis.size() >= 2;
    chk("acc0", 64'(in0_accept_o), 64'(ea0));
    chk("acc1", 64'(in1_accept_o), 64'(ea1));
    chk("lvl", 64'(level_o), rs ? 64'(q.size()) : 64'd0);
    chk("v0", 64'(out0_valid_o), 64'(ev0));
    chk("v1", 64'(out1_valid_o), 64'(ev1));
    if (ev0) begin
      chk("o0.instr", 64'(out0_instr_o), 64'(vis[0].instr));
      chk("o0.pc", 64'(out0_pc_o), 64'(vis[0].pc));
      chk("o0.ff", {out0_fault_o, out0_flags_o}, {vis[0].fault, vis[0].flags});
    end
    if (ev1) begin
      chk("o1.instr", 64'(out1_instr_o), 64'(vis[1].instr));
      chk("o1.pc", 64'(out1_pc_o), 64'(vis[1].pc));
      chk("o1.ff", {out1_fault_o, out1_flags_o}, {vis[1].fault, vis[1].flags});
    end
    if (!rs) begin
      chk("rst.d0", {out0_instr_o, out0_pc_o}, 64'd0);
      chk("rst.d1", {out1_instr_o, out1_pc_o}, 64'd0);
    end
    c0 = ev0 && a0;
    c1 = c0 && ev1 && a1;
    if (c0) begin
      chk("order", 64'(out0_pc_o > last_pc), 64'd1);
      last_pc = vis[0].pc;
      if (c1) last_pc = vis[1].pc;
    end
    @(posedge clk_i);
    if (!rs || fl) q.delete();
    else begin
      q = lst;
      if (c0) void'(q.pop_front());
      if (c1) void'(q.pop_front());
    end
    if (p0) next_pc += 4;
    if (p1) next_pc += 4;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  initial begin
    phase = "reset";
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 1, 1, 1, 0, 0, 32'h1, 32'h2);

    phase = "first";
    next_pc = 32'h8000_0000;
    last_pc = 32'h0;
    step(1, 1, 0, 0, 0, 1, 32'h0000_0013, 32'h0010_0093);
    idle();

    phase = "fill";
    repeat (5) step(1, 1, 0, 0, 0, 1, $urandom, $urandom);

    phase = "drain4";
    repeat (4) step(0, 0, 1, 0, 0, 1, 32'h0, 32'h0);
    phase = "a1only";
    repeat (2) step(0, 0, 0, 1, 0, 1, 32'h0, 32'h0);

    phase = "steady";
    step(0, 0, 1, 0, 0, 1, 32'h0, 32'h0);
    repeat (20) step(1, 1, 1, 1, 0, 1, $urandom, $urandom);

    phase = "flush";
    repeat (2) step(1, 0, 0, 0, 0, 1, $urandom, 32'h0);
    step(1, 1, 1, 1, 1, 1, $urandom, $urandom);
    idle();
    idle();

    phase = "midreset";
    repeat (3) step(1, 1, 0, 0, 0, 1, $urandom, $urandom);
    step(1, 1, 1, 1, 0, 0, $urandom, $urandom);
    idle();
    step(1, 1, 1, 0, 0, 1, $urandom, $urandom);
    idle();

    phase = "random";
    repeat (400) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0,
           $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
